// File: rtl/irq_aggregator.sv
// Avalon-MM interrupt aggregator: synchronises and edge-detects up to 32 sources,
// latches events as pending, masks them with enable and reports the highest-priority one.
module irq_aggregator #(
    parameter int N_SRC = 8
) (
    input  logic             FPGA_CLK1_50,
    input  logic             reset,
    input  logic [N_SRC-1:0] src_irq,
    input  logic [2:0]       avl_address,
    input  logic             avl_read,
    input  logic             avl_write,
    input  logic [31:0]      avl_writedata,
    output logic [31:0]      avl_readdata,
    output logic             avl_irq
);

    typedef enum logic [2:0] {
        REG_STATUS  = 3'd0,
        REG_PENDING = 3'd1,
        REG_ENABLE  = 3'd2,
        REG_ACTIVE  = 3'd3,
        REG_VECTOR  = 3'd4,
        REG_ACK     = 3'd5,
        REG_RSVD6   = 3'd6,
        REG_RSVD7   = 3'd7
    } reg_addr_t;

    logic [N_SRC-1:0] s1, s2, s3;
    logic [N_SRC-1:0] pending, enable, active;
    logic [N_SRC-1:0] rise, clr, ack_mask;
    logic [1:0]       warm;
    logic             armed;
    logic             wr_pending, wr_enable, wr_ack;
    logic             vec_valid;
    logic [7:0]       vec_idx;
    logic [31:0]      vector_word;
    logic [31:0]      read_mux;
    logic             unused_wdata;

    assign unused_wdata = ^avl_writedata;

    // The chain is empty right after reset, so s2 & ~s3 would fake an edge for any
    // source already high; edges are ignored until s3 holds a real sample.
    assign armed = (warm == 2'd3);
    assign rise  = armed ? (s2 & ~s3) : '0;

    assign wr_pending = avl_write && (reg_addr_t'(avl_address) == REG_PENDING);
    assign wr_enable  = avl_write && (reg_addr_t'(avl_address) == REG_ENABLE);
    assign wr_ack     = avl_write && (reg_addr_t'(avl_address) == REG_ACK);

    always_comb begin
        ack_mask = '0;
        for (int i = 0; i < N_SRC; i++) begin
            ack_mask[i] = (avl_writedata[7:0] == 8'(i));
        end
    end

    assign clr = ({N_SRC{wr_pending}} & avl_writedata[N_SRC-1:0])
               | ({N_SRC{wr_ack}} & ack_mask);

    assign active = pending & enable;

    // Fixed priority: scanning downwards lets the lowest active index win.
    always_comb begin
        vec_valid = |active;
        vec_idx   = 8'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                vec_idx = 8'(i);
            end
        end
    end

    assign vector_word = vec_valid ? {1'b1, 23'd0, vec_idx} : 32'd0;

    always_comb begin
        read_mux = 32'd0;
        case (reg_addr_t'(avl_address))
            REG_STATUS:  read_mux = 32'(s2);
            REG_PENDING: read_mux = 32'(pending);
            REG_ENABLE:  read_mux = 32'(enable);
            REG_ACTIVE:  read_mux = 32'(active);
            REG_VECTOR:  read_mux = vector_word;
            default:     read_mux = 32'd0;
        endcase
    end

    always_ff @(posedge FPGA_CLK1_50) begin
        if (reset) begin
            s1      <= '0;
            s2      <= '0;
            s3      <= '0;
            warm    <= 2'd0;
            pending <= '0;
            enable  <= '0;
            avl_irq <= 1'b0;
        end else begin
            s1 <= src_irq;
            s2 <= s1;
            s3 <= s2;
            if (!armed) begin
                warm <= warm + 2'd1;
            end
            pending <= (pending & ~clr) | rise;
            if (wr_enable) begin
                enable <= avl_writedata[N_SRC-1:0];
            end
            avl_irq <= |active;
        end
    end

    always_ff @(posedge FPGA_CLK1_50) begin
        if (reset) begin
            avl_readdata <= 32'd0;
        end else if (avl_read) begin
            avl_readdata <= read_mux;
        end
    end

endmodule
